dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-side memory responder for the single-cycle RISC-V core. It services the core's load/store port with byte-addressable RAM and a small memory-mapped register window.
- Loads are combinational, so the data is returned in the same cycle as the request, as the single-cycle core requires.
- Stores, MMIO updates, the free-running cycle counter and sticky error flags are all sequential.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit RAM words. Must be a power of 2. RAM spans byte addresses 0 .. 4*DEPTH_WORDS-1.
- MMIO_BASE, 32'hFFFF_0000: base byte address of the 4-register MMIO window.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- W_en  in  1  store request this cycle
- R_en  in  1  load request this cycle
- RW_type  in  3  access type, func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ram_addr  in  32  byte address
- store_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- load_data  out  32  load result, extended per RW_type
- led_out  out  32  MMIO scratch/LED register value
- err_misalign  out  1  sticky misaligned-access flag
- err_range  out  1  sticky unmapped-address / illegal-type flag

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - cycle counter = 0, led_out = 0, err_misalign = 0, err_range = 0.
  - RAM contents are not cleared.
  - load_data is combinational and carries no reset value.
- Address map:
  - RAM hit when ram_addr < 4*DEPTH_WORDS. Word index = ram_addr[log2(DEPTH_WORDS)+1:2], lane = ram_addr[1:0].
  - MMIO hit when ram_addr[31:4] == MMIO_BASE[31:4]:
    - +0: CNT_LO, read-only.
    - +4: CNT_HI, read-only.
    - +8: LED, read/write.
    - +C: STATUS, read/write. bit0 = err_misalign, bit1 = err_range; write-1-to-clear.
  - Any other address is unmapped.
- Legality. An access is illegal if any of the following holds:
  - RW_type is 011, 110 or 111 (range error).
  - Half access with ram_addr[0]=1 (misaligned).
  - Word access with ram_addr[1:0]!=0 (misaligned).
  - Address is unmapped (range error).
  - MMIO access is not a word access (range error).
- Illegal-access response:
  - No state is written.
  - load_data = 0.
  - At the next edge the matching sticky flag is set. It is set only when R_en or W_en is high.
- Loads (R_en=1, legal), same cycle:
  - B: selected lane, sign-extended.
  - BU: selected lane, zero-extended.
  - H: lanes {addr[1],0} pair, sign-extended.
  - HU: same pair, zero-extended.
  - W: full word.
  - Little-endian: lane 0 = bits [7:0].
  - MMIO reads return the register value as held before the current edge.
- R_en=0: load_data = 0.
- Stores (W_en=1, legal), at the rising edge:
  - B writes only the addressed lane with store_data[7:0].
  - H writes only the two lanes with store_data[15:0].
  - W writes all four lanes.
  - Unaddressed lanes are preserved.
  - Writes to CNT_LO/CNT_HI are ignored (no error).
  - A write to LED loads led_out.
  - A write to STATUS clears each flag whose data bit is 1.
- Cycle counter:
  - 64-bit, increments by 1 every cycle when not in reset; wraps from 2^64-1 to 0.
  - CNT_LO/CNT_HI return the pre-edge value.
- Simultaneous events:
  - R_en and W_en both high at the same address: load_data shows the old contents; the write takes effect at the edge.
  - STATUS write-1-to-clear and a new error in the same cycle: set wins.
  - Reset asserted in the same cycle as a store: reset wins for registers. The RAM write still occurs.
- No internal handshake. Every request completes in its own cycle; there are no wait states.

Test Plan:
- Reset, then write W 0x11223344 to 0x10. Read back as B@0x11 -> 0x00000033; BU@0x13 -> 0x00000011; H@0x12 -> 0x00001122; W -> 0x11223344.
- Store B 0xFF to 0x21 over an existing word 0x00000000. Read W 0x20 -> 0x0000FF00. Read B 0x21 -> 0xFFFFFFFF. Read BU 0x21 -> 0x000000FF.
- H store to 0x03 (misaligned):
  - load_data = 0 and RAM is unchanged.
  - err_misalign = 1 after the edge and remains set.
  - W store 0x1 to MMIO_BASE+C -> err_misalign = 0.
  - Repeating the misaligned access in the same cycle as the clear -> the flag stays 1.
- After reset, hold idle 10 cycles, then read CNT_LO -> 10 (±0, counted from the reset-deassert edge). Write CNT_LO -> value unaffected, no error.
- W store 0xA5A5A5A5 to MMIO_BASE+8 -> led_out = 0xA5A5A5A5. Assert rst_n=0 for one edge -> led_out = 0, counter = 0, and the RAM word at 0x10 still reads 0x11223344.
- Access address 4*DEPTH_WORDS, RW_type 011 at 0x0, and a B access to MMIO_BASE -> each sets err_range, returns load_data = 0, and causes no state change.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-side RAM and MMIO responder for the single-cycle RISC-V core
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        W_en,
    input  logic        R_en,
    input  logic [2:0]  RW_type,
    input  logic [31:0] ram_addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] led_out,
    output logic        err_misalign,
    output logic        err_range
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]   mem [DEPTH_WORDS];
    logic [63:0]   cnt;
    logic          sz_b, sz_h, sz_w, type_bad, ram_hit, mmio_hit, mis, rng, legal, req;
    logic          wr_ram, wr_led, wr_status;
    logic [AW-1:0] idx;
    logic [31:0]   word, wdata;
    logic [3:0]    be;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    // Decode access size, address map and legality of the current request
    always_comb begin
        sz_b      = RW_type[1:0] == 2'b00;
        sz_h      = RW_type[1:0] == 2'b01;
        sz_w      = RW_type == 3'b010;
        type_bad  = RW_type == 3'b011 || RW_type[2:1] == 2'b11;
        ram_hit   = ram_addr < 32'(4 * DEPTH_WORDS);
        mmio_hit  = ram_addr[31:4] == MMIO_BASE[31:4];
        mis       = (sz_h && ram_addr[0]) || (sz_w && ram_addr[1:0] != 2'b00);
        rng       = type_bad || !(ram_hit || mmio_hit) || (mmio_hit && !sz_w);
        legal     = !mis && !rng;
        req       = W_en || R_en;
        wr_ram    = W_en && legal && ram_hit;
        wr_led    = W_en && legal && mmio_hit && ram_addr[3:2] == 2'd2;
        wr_status = W_en && legal && mmio_hit && ram_addr[3:2] == 2'd3;
        idx       = ram_addr[AW+1:2];
        wdata     = sz_b ? {4{store_data[7:0]}} : sz_h ? {2{store_data[15:0]}} : store_data;
        be        = sz_w ? 4'hF : sz_h ? (ram_addr[1] ? 4'hC : 4'h3) : 4'b0001 << ram_addr[1:0];
    end

    // Combinational load path: select source word, then extract and extend the addressed lanes
    always_comb begin
        word      = !mmio_hit ? mem[idx] :
                    ram_addr[3:2] == 2'd0 ? cnt[31:0] :
                    ram_addr[3:2] == 2'd1 ? cnt[63:32] :
                    ram_addr[3:2] == 2'd2 ? led_out : {30'd0, err_range, err_misalign};
        lane_b    = word[{ram_addr[1:0], 3'b000} +: 8];
        lane_h    = ram_addr[1] ? word[31:16] : word[15:0];
        load_data = !(R_en && legal) ? 32'd0 :
                    sz_w ? word :
                    sz_h ? {{16{lane_h[15] & ~RW_type[2]}}, lane_h} :
                    {{24{lane_b[7] & ~RW_type[2]}}, lane_b};
    end

    // RAM byte-lane writes; deliberately independent of reset so a store still lands during reset
    always_ff @(posedge clk) begin
        if (wr_ram)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    // Cycle counter, LED register and sticky error flags (a new error beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= 64'd0;
            led_out      <= 32'd0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            cnt          <= cnt + 64'd1;
            if (wr_led) led_out <= store_data;
            err_misalign <= (err_misalign & ~(wr_status & store_data[0])) | (req & mis);
            err_range    <= (err_range & ~(wr_status & store_data[1])) | (req & rng);
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam logic [31:0] MB = 32'hFFFF_0000;
    localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        W_en = 0;
    logic        R_en = 0;
    logic [2:0]  RW_type = T_W;
    logic [31:0] ram_addr = 0;
    logic [31:0] store_data = 0;
    logic [31:0] load_data, led_out;
    logic        err_misalign, err_range;
    int          total = 0;
    int          bad = 0;

    dmem_responder dut (
        .clk(clk), .rst_n(rst_n), .W_en(W_en), .R_en(R_en), .RW_type(RW_type),
        .ram_addr(ram_addr), .store_data(store_data), .load_data(load_data),
        .led_out(led_out), .err_misalign(err_misalign), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one request for the cycle starting at the next falling edge
    task automatic access(input logic we, input logic re, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        W_en = we; R_en = re; RW_type = t; ram_addr = a; store_data = d;
        #1;
    endtask

    task automatic idle();
        access(1'b0, 1'b0, T_W, 32'd0, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_led", led_out, 32'd0);
        check("rst_errm", {31'd0, err_misalign}, 32'd0);
        check("rst_errr", {31'd0, err_range}, 32'd0);
        check("rdis_zero", load_data, 32'd0);
        repeat (10) @(posedge clk);
        access(0, 1, T_W, MB, 0);
        check("cnt_lo10", load_data, 32'd10);
        access(0, 1, T_W, MB + 4, 0);
        check("cnt_hi", load_data, 32'd0);
        access(1, 0, T_W, MB, 32'hDEAD_BEEF);
        access(0, 1, T_W, MB, 0);
        check("cnt_lo_wr_ign", load_data, 32'd13);
        check("cnt_wr_errm", {31'd0, err_misalign}, 32'd0);
        check("cnt_wr_errr", {31'd0, err_range}, 32'd0);

        access(1, 0, T_W, 32'h10, 32'h1122_3344);
        access(0, 1, T_B, 32'h11, 0);
        check("ld_b11", load_data, 32'h0000_0033);
        access(0, 1, T_BU, 32'h13, 0);
        check("ld_bu13", load_data, 32'h0000_0011);
        access(0, 1, T_H, 32'h12, 0);
        check("ld_h12", load_data, 32'h0000_1122);
        access(0, 1, T_HU, 32'h10, 0);
        check("ld_hu10", load_data, 32'h0000_3344);
        access(0, 1, T_W, 32'h10, 0);
        check("ld_w10", load_data, 32'h1122_3344);

        access(1, 0, T_W, 32'h20, 32'h0);
        access(1, 0, T_B, 32'h21, 32'h0000_00FF);
        access(0, 1, T_W, 32'h20, 0);
        check("sb_w20", load_data, 32'h0000_FF00);
        access(0, 1, T_B, 32'h21, 0);
        check("sb_b21", load_data, 32'hFFFF_FFFF);
        access(0, 1, T_BU, 32'h21, 0);
        check("sb_bu21", load_data, 32'h0000_00FF);
        access(1, 0, T_H, 32'h22, 32'hABCD_8001);
        access(0, 1, T_H, 32'h22, 0);
        check("sh_h22", load_data, 32'hFFFF_8001);
        access(1, 1, T_W, 32'h20, 32'h1234_5678);
        check("rw_old", load_data, 32'h8001_FF00);
        access(0, 1, T_W, 32'h20, 0);
        check("rw_new", load_data, 32'h1234_5678);

        access(1, 0, T_W, 32'h00, 32'hCAFE_BABE);
        access(1, 1, T_H, 32'h03, 32'h0000_1234);
        check("mis_ld0", load_data, 32'd0);
        idle();
        check("mis_errm", {31'd0, err_misalign}, 32'd1);
        check("mis_errr", {31'd0, err_range}, 32'd0);
        access(0, 1, T_W, 32'h00, 0);
        check("mis_ram", load_data, 32'hCAFE_BABE);
        access(0, 1, T_W, MB + 12, 0);
        check("status_rd", load_data, 32'd1);
        check("mis_sticky", {31'd0, err_misalign}, 32'd1);
        access(1, 0, T_W, MB + 12, 32'd1);
        idle();
        check("w1c_errm", {31'd0, err_misalign}, 32'd0);
        access(1, 0, T_W, MB + 14, 32'd1);
        idle();
        check("mis_stat_errm", {31'd0, err_misalign}, 32'd1);
        check("mis_stat_errr", {31'd0, err_range}, 32'd0);

        access(1, 0, T_W, MB + 8, 32'hA5A5_A5A5);
        idle();
        check("led_wr", led_out, 32'hA5A5_A5A5);
        @(negedge clk);
        rst_n = 0; W_en = 1; R_en = 0; RW_type = T_W; ram_addr = 32'h40; store_data = 32'h5566_7788;
        @(negedge clk);
        rst_n = 1; W_en = 0; R_en = 1; RW_type = T_W; ram_addr = MB;
        #1;
        check("rst2_cnt", load_data, 32'd0);
        check("rst2_led", led_out, 32'd0);
        check("rst2_errm", {31'd0, err_misalign}, 32'd0);
        access(0, 1, T_W, 32'h10, 0);
        check("rst2_ram10", load_data, 32'h1122_3344);
        access(0, 1, T_W, 32'h40, 0);
        check("rst2_ram40", load_data, 32'h5566_7788);

        access(1, 0, T_W, MB + 8, 32'h1234_5678);
        access(1, 1, T_W, 32'd1024, 32'h9999_9999);
        check("oor_ld", load_data, 32'd0);
        idle();
        check("oor_errr", {31'd0, err_range}, 32'd1);
        check("oor_errm", {31'd0, err_misalign}, 32'd0);
        access(0, 1, T_W, 32'h00, 0);
        check("oor_ram", load_data, 32'hCAFE_BABE);
        access(1, 0, T_W, MB + 12, 32'd2);
        idle();
        check("w1c_errr", {31'd0, err_range}, 32'd0);
        access(1, 1, 3'b011, 32'h00, 32'h0);
        check("t011_ld", load_data, 32'd0);
        idle();
        check("t011_errr", {31'd0, err_range}, 32'd1);
        access(0, 1, T_W, 32'h00, 0);
        check("t011_ram", load_data, 32'hCAFE_BABE);
        access(1, 0, T_W, MB + 12, 32'd2);
        access(1, 1, T_B, MB + 8, 32'h0000_00FF);
        check("mmiob_ld", load_data, 32'd0);
        idle();
        check("mmiob_errr", {31'd0, err_range}, 32'd1);
        check("mmiob_led", led_out, 32'h1234_5678);
        access(1, 0, T_W, MB + 12, 32'd2);
        access(0, 0, 3'b111, 32'h00, 32'h0);
        idle();
        check("noreq_errr", {31'd0, err_range}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
